// File: rtl/exu_wb_arb_pkg.sv
// Shared types for the execute-stage writeback arbiter: request payload,
// source count and source indices (index order is also priority order).
package exu_wb_arb_pkg;

  localparam int WB_XLEN    = 32;
  localparam int NUM_WB_SRC = 3;

  typedef enum logic [1:0] {
    WB_LSU = 2'd0,
    WB_MUL = 2'd1,
    WB_ALU = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [WB_XLEN-1:0] data;
    logic [4:0]         rd_addr;
    logic [WB_XLEN-1:0] tag;
  } wb_req_t;

endpackage

// File: rtl/exu_wb_arb_dff_rst.sv
// Enabled register with synchronous active-low clear.
module dff_rst #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/exu_wb_arb_wb_fifo.sv
// Per-source result buffer. A push while full is dropped unless the same
// cycle also pops; ovf flags the dropped push.
module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count_nxt,
  output logic                   ovf
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full      = (count == (AW+1)'(DEPTH));
    empty     = (count == '0);
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    ovf       = push && full && !do_pop;
    count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head      = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: merges ALU/MUL/LSU results onto one register-file write
// port with fixed priority LSU > MUL > ALU, buffering losers per source.
module exu_wb_arb
  import exu_wb_arb_pkg::*;
#(
  parameter int XLEN     = 32,  // must equal WB_XLEN of the shared package
  parameter int DEPTH    = 4,
  parameter int STALL_TH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_wb_rd_wr_en,
  input  logic [4:0]      alu_wb_rd_addr,
  input  logic [XLEN-1:0] alu_wb_data,
  input  logic [XLEN-1:0] alu_instr_tag,
  input  logic            mul_wb_rd_wr_en,
  input  logic [4:0]      mul_wb_rd_addr,
  input  logic [XLEN-1:0] mul_wb_data,
  input  logic [XLEN-1:0] mul_instr_tag,
  input  logic            lsu_wb_rd_wr_en,
  input  logic [4:0]      lsu_wb_rd_addr,
  input  logic [XLEN-1:0] lsu_wb_data,
  input  logic [XLEN-1:0] lsu_instr_tag,
  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  output logic [XLEN-1:0] wb_instr_tag,
  output logic            wb_stall,
  output logic            wb_ovf_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t                 in_req [NUM_WB_SRC];
  wb_req_t                 head   [NUM_WB_SRC];
  wb_req_t                 cand   [NUM_WB_SRC];
  logic [CW-1:0]           cnt_nxt [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0]   in_vld;
  logic [NUM_WB_SRC-1:0]   fifo_empty;
  logic [NUM_WB_SRC-1:0]   has_cand;
  logic [NUM_WB_SRC-1:0]   win;
  logic [NUM_WB_SRC-1:0]   push;
  logic [NUM_WB_SRC-1:0]   pop;
  logic [NUM_WB_SRC-1:0]   ovf;
  wb_req_t                 win_req;
  wb_req_t                 wb_q;
  logic                    stall_nxt;

  // Writes to x0 are dropped at the door so they never occupy a slot.
  always_comb begin
    in_req[WB_LSU] = '{data: lsu_wb_data, rd_addr: lsu_wb_rd_addr, tag: lsu_instr_tag};
    in_req[WB_MUL] = '{data: mul_wb_data, rd_addr: mul_wb_rd_addr, tag: mul_instr_tag};
    in_req[WB_ALU] = '{data: alu_wb_data, rd_addr: alu_wb_rd_addr, tag: alu_instr_tag};
    in_vld[WB_LSU] = lsu_wb_rd_wr_en && (lsu_wb_rd_addr != 5'd0);
    in_vld[WB_MUL] = mul_wb_rd_wr_en && (mul_wb_rd_addr != 5'd0);
    in_vld[WB_ALU] = alu_wb_rd_wr_en && (alu_wb_rd_addr != 5'd0);
  end

  // A buffered head always takes precedence over its own input, keeping
  // per-source order; an empty FIFO lets a valid input bypass straight out.
  always_comb begin
    win       = '0;
    win_req   = '0;
    stall_nxt = 1'b0;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      has_cand[s] = !fifo_empty[s] || in_vld[s];
      cand[s]     = fifo_empty[s] ? in_req[s] : head[s];
    end
    if (has_cand[WB_LSU])      win[WB_LSU] = 1'b1;
    else if (has_cand[WB_MUL]) win[WB_MUL] = 1'b1;
    else if (has_cand[WB_ALU]) win[WB_ALU] = 1'b1;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      pop[s]  = win[s] && !fifo_empty[s];
      push[s] = in_vld[s] && !(fifo_empty[s] && win[s]);
      if (win[s]) win_req = cand[s];
      if ((DEPTH - int'(cnt_nxt[s])) <= STALL_TH) stall_nxt = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_WB_SRC; g++) begin : g_fifo
    wb_fifo #(
      .DEPTH(DEPTH),
      .T    (wb_req_t)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[g]),
      .pop      (pop[g]),
      .din      (in_req[g]),
      .head     (head[g]),
      .empty    (fifo_empty[g]),
      .count_nxt(cnt_nxt[g]),
      .ovf      (ovf[g])
    );
  end

  // Payload holds its last value when nothing retires.
  dff_rst #(.W($bits(wb_req_t))) u_wb_q (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (|win),
    .d    (win_req),
    .q    (wb_q)
  );

  dff_rst #(.W(3)) u_flags_q (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .d    ({|win, stall_nxt, wb_ovf_err | (|ovf)}),
    .q    ({rf_wr_en, wb_stall, wb_ovf_err})
  );

  assign rf_wr_addr   = wb_q.rd_addr;
  assign rf_wr_data   = wb_q.data;
  assign wb_instr_tag = wb_q.tag;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Bench for exu_wb_arb: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the arbitration rules.
module tb_exu_wb_arb;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 4;
  localparam int STALL_TH = 2;
  localparam int NSRC     = 3;  // model index 0=LSU, 1=MUL, 2=ALU (priority order)

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] tag;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            alu_wb_rd_wr_en, mul_wb_rd_wr_en, lsu_wb_rd_wr_en;
  logic [4:0]      alu_wb_rd_addr, mul_wb_rd_addr, lsu_wb_rd_addr;
  logic [XLEN-1:0] alu_wb_data, mul_wb_data, lsu_wb_data;
  logic [XLEN-1:0] alu_instr_tag, mul_instr_tag, lsu_instr_tag;
  logic            rf_wr_en, wb_stall, wb_ovf_err;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data, wb_instr_tag;

  exu_wb_arb #(.XLEN(XLEN), .DEPTH(DEPTH), .STALL_TH(STALL_TH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_rd_wr_en(alu_wb_rd_wr_en), .alu_wb_rd_addr(alu_wb_rd_addr),
    .alu_wb_data(alu_wb_data), .alu_instr_tag(alu_instr_tag),
    .mul_wb_rd_wr_en(mul_wb_rd_wr_en), .mul_wb_rd_addr(mul_wb_rd_addr),
    .mul_wb_data(mul_wb_data), .mul_instr_tag(mul_instr_tag),
    .lsu_wb_rd_wr_en(lsu_wb_rd_wr_en), .lsu_wb_rd_addr(lsu_wb_rd_addr),
    .lsu_wb_data(lsu_wb_data), .lsu_instr_tag(lsu_instr_tag),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .wb_instr_tag(wb_instr_tag), .wb_stall(wb_stall), .wb_ovf_err(wb_ovf_err)
  );

  // ---------------- stimulus state ----------------
  logic       in_v [NSRC];
  req_t       in_r [NSRC];

  // ---------------- scoreboard / model ----------------
  req_t            mq [NSRC][$];
  logic            exp_en, exp_stall, exp_ovf;
  logic [4:0]      exp_addr;
  logic [XLEN-1:0] exp_data, exp_tag;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] act,
                          input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  // Model of one clock edge: oldest candidate per source, LSU > MUL > ALU.
  task automatic model_edge();
    bit   found = 0;
    bit   byp [NSRC];
    req_t w = '0;
    if (!rst_n) begin
      for (int s = 0; s < NSRC; s++) mq[s].delete();
      exp_en = 0; exp_addr = 0; exp_data = 0; exp_tag = 0;
      exp_stall = 0; exp_ovf = 0;
      return;
    end
    for (int s = 0; s < NSRC; s++) begin
      byp[s] = 0;
      if (!found) begin
        if (mq[s].size() > 0) begin
          w = mq[s].pop_front();
          found = 1;
        end else if (in_v[s] && in_r[s].rd != 0) begin
          w = in_r[s];
          found = 1;
          byp[s] = 1;
        end
      end
    end
    for (int s = 0; s < NSRC; s++) begin
      if (in_v[s] && in_r[s].rd != 0 && !byp[s]) begin
        if (mq[s].size() < DEPTH) mq[s].push_back(in_r[s]);
        else exp_ovf = 1;
      end
    end
    exp_en = found;
    if (found) begin
      exp_addr = w.rd; exp_data = w.data; exp_tag = w.tag;
    end
    exp_stall = 0;
    for (int s = 0; s < NSRC; s++)
      if (mq[s].size() >= DEPTH - STALL_TH) exp_stall = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_inputs();
    lsu_wb_rd_wr_en = in_v[0]; lsu_wb_rd_addr = in_r[0].rd;
    lsu_wb_data = in_r[0].data; lsu_instr_tag = in_r[0].tag;
    mul_wb_rd_wr_en = in_v[1]; mul_wb_rd_addr = in_r[1].rd;
    mul_wb_data = in_r[1].data; mul_instr_tag = in_r[1].tag;
    alu_wb_rd_wr_en = in_v[2]; alu_wb_rd_addr = in_r[2].rd;
    alu_wb_data = in_r[2].data; alu_instr_tag = in_r[2].tag;
  endtask

  task automatic set_idle();
    for (int s = 0; s < NSRC; s++) begin
      in_v[s] = 0;
      in_r[s] = '0;
    end
  endtask

  task automatic set_src(input int s, input logic [4:0] rd,
                         input logic [XLEN-1:0] data, input logic [XLEN-1:0] tag);
    in_v[s] = 1;
    in_r[s] = '{rd: rd, data: data, tag: tag};
  endtask

  // Drive current inputs, advance one edge, compare everything.
  task automatic step();
    apply_inputs();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("rf_wr_en",     XLEN'(rf_wr_en),   XLEN'(exp_en));
    check_eq("rf_wr_addr",   XLEN'(rf_wr_addr), XLEN'(exp_addr));
    check_eq("rf_wr_data",   rf_wr_data,        exp_data);
    check_eq("wb_instr_tag", wb_instr_tag,      exp_tag);
    check_eq("wb_stall",     XLEN'(wb_stall),   XLEN'(exp_stall));
    check_eq("wb_ovf_err",   XLEN'(wb_ovf_err), XLEN'(exp_ovf));
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rate [NSRC];
    rst_n = 0;
    set_idle();
    step();
    step();
    rst_n = 1;
    idle_cycles(2);

    // Single uncontested ALU write.
    set_idle(); set_src(2, 5'd5, 32'h0000_00AA, 32'h10); step();
    check_eq("alu_single_data", rf_wr_data, 32'h0000_00AA);
    idle_cycles(2);

    // ALU x1 and LSU x2 together: LSU first, ALU next.
    set_idle(); set_src(2, 5'd1, 32'd1, 32'h21); set_src(0, 5'd2, 32'd2, 32'h22); step();
    check_eq("lsu_first_addr", XLEN'(rf_wr_addr), 32'd2);
    idle_cycles(1);
    check_eq("alu_second_addr", XLEN'(rf_wr_addr), 32'd1);
    idle_cycles(1);

    // Both busy 4 cycles: ALU backs up to the stall threshold, then drains.
    for (int i = 0; i < 4; i++) begin
      set_idle();
      set_src(0, 5'(10 + i), 32'h100 + i, 32'h300 + i);
      set_src(2, 5'(20 + i), 32'h200 + i, 32'h400 + i);
      step();
    end
    check_eq("stall_at_th", XLEN'(wb_stall), 32'd1);
    idle_cycles(6);

    // Writes to x0 are discarded.
    set_idle(); set_src(2, 5'd0, 32'hDEAD, 32'h55); step();
    check_eq("x0_no_write", XLEN'(rf_wr_en), 32'd0);
    idle_cycles(1);

    // Overflow: five ALU results while LSU holds the port.
    for (int i = 0; i < 5; i++) begin
      set_idle();
      set_src(0, 5'(3 + i), 32'h500 + i, 32'h600 + i);
      set_src(2, 5'(8 + i), 32'h700 + i, 32'h800 + i);
      step();
    end
    idle_cycles(1);
    check_eq("ovf_set", XLEN'(wb_ovf_err), 32'd1);
    idle_cycles(6);
    check_eq("ovf_sticky", XLEN'(wb_ovf_err), 32'd1);

    // Reset with three buffered entries, then a fresh ALU write.
    for (int i = 0; i < 3; i++) begin
      set_idle();
      set_src(0, 5'(12 + i), 32'h900 + i, 32'hA00 + i);
      set_src(2, 5'(16 + i), 32'hB00 + i, 32'hC00 + i);
      step();
    end
    rst_n = 0;
    set_idle(); set_src(2, 5'd9, 32'h999, 32'h999); step();
    rst_n = 1;
    set_idle(); set_src(2, 5'd7, 32'd7, 32'h77); step();
    check_eq("post_rst_alu", XLEN'(rf_wr_addr), 32'd7);
    idle_cycles(2);

    // Random traffic with phase-varying load and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0)
        for (int s = 0; s < NSRC; s++) rate[s] = $urandom_range(5, 80);
      rst_n = ($urandom_range(0, 249) != 0);
      for (int s = 0; s < NSRC; s++) begin
        in_v[s] = ($urandom_range(0, 99) < rate[s]);
        in_r[s] = '{rd: 5'($urandom_range(0, 31)), data: $urandom, tag: $urandom};
      end
      step();
    end
    rst_n = 1;
    idle_cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
